// File: rtl/operand_fwd_buffer.sv
// Operand forwarding buffer.
// Selects each decode operand from the youngest in-flight producer:
// EX, then MEM, then WB, then the register file.
// Also raises a one-cycle load-use stall and absorbs pipeline flushes.
// Operand slot 0 is rs1/opr_a; slot 1 is rs2/opr_b.
module operand_fwd_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        ex_valid,
    input  logic        ex_reg_wr,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] opr_res,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    output logic [31:0] fwd_opr_a,
    output logic [31:0] fwd_opr_b,
    output logic [1:0]  fwd_sel_a,
    output logic [1:0]  fwd_sel_b,
    output logic        opr_valid,
    output logic        stall
);
    localparam int NUM_OPR = 2;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // MEM record: the instruction that was in EX on the previous cycle.
    logic                           m_valid_q;
    logic                           m_wr_q;
    logic                           m_load_q;
    logic [4:0]                     m_rd_q;
    logic [31:0]                    m_res_q;

    // WB record: the instruction that was in MEM on the previous cycle.
    logic                           w_valid_q;
    logic                           w_wr_q;
    logic [4:0]                     w_rd_q;
    logic [31:0]                    w_data_q;

    // Per-operand views of the decode request and the selection.
    logic [NUM_OPR-1:0][4:0]        rs;
    logic [NUM_OPR-1:0][31:0]       rf_data;
    logic [NUM_OPR-1:0]             ex_hit;
    logic [NUM_OPR-1:0]             m_hit;
    logic [NUM_OPR-1:0]             w_hit;
    logic [NUM_OPR-1:0]             ld_hazard;
    logic [NUM_OPR-1:0][1:0]        sel_d;
    logic [NUM_OPR-1:0][1:0]        sel_q;
    logic [NUM_OPR-1:0][31:0]       opr_d;
    logic [NUM_OPR-1:0][31:0]       opr_q;
    logic                           opr_valid_q;

    // A load in MEM returns its data this cycle on mem_rdata.
    // Forward that data instead of the address-phase ALU result.
    logic [31:0]                    m_data;

    assign rs      = {id_rs2, id_rs1};
    assign rf_data = {rf_rs2_data, rf_rs1_data};
    assign m_data  = m_load_q ? mem_rdata : m_res_q;

    // Per-operand producer match and youngest-first source priority.
    // An x0 source never matches, so it always falls through to the register file.
    always_comb begin
        ex_hit    = '0;
        m_hit     = '0;
        w_hit     = '0;
        ld_hazard = '0;
        sel_d     = '0;
        opr_d     = rf_data;
        for (int i = 0; i < NUM_OPR; i++) begin
            ex_hit[i]    = ex_valid & ex_reg_wr & (ex_rd == rs[i]) & (rs[i] != 5'd0);
            m_hit[i]     = m_valid_q & m_wr_q & (m_rd_q == rs[i]) & (rs[i] != 5'd0);
            w_hit[i]     = w_valid_q & w_wr_q & (w_rd_q == rs[i]) & (rs[i] != 5'd0);
            ld_hazard[i] = ex_hit[i] & ex_is_load;
            if (ex_hit[i]) begin
                sel_d[i] = SEL_EX;
                opr_d[i] = opr_res;
            end else if (m_hit[i]) begin
                sel_d[i] = SEL_MEM;
                opr_d[i] = m_data;
            end else if (w_hit[i]) begin
                sel_d[i] = SEL_WB;
                opr_d[i] = w_data_q;
            end else begin
                sel_d[i] = SEL_RF;
                opr_d[i] = rf_data[i];
            end
        end
    end

    // A load in EX cannot forward yet, so decode holds one cycle.
    // Flush and reset both cancel the hold request.
    assign stall = id_valid & (|ld_hazard) & ~flush & ~rst;

    // Advance the MEM and WB producer records.
    // Flush kills only the EX instruction entering MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_wr_q    <= 1'b0;
            m_load_q  <= 1'b0;
            m_rd_q    <= 5'd0;
            m_res_q   <= 32'd0;
            w_valid_q <= 1'b0;
            w_wr_q    <= 1'b0;
            w_rd_q    <= 5'd0;
            w_data_q  <= 32'd0;
        end else begin
            m_valid_q <= ex_valid & ~flush;
            m_wr_q    <= ex_reg_wr;
            m_load_q  <= ex_is_load;
            m_rd_q    <= ex_rd;
            m_res_q   <= opr_res;
            w_valid_q <= m_valid_q;
            w_wr_q    <= m_wr_q;
            w_rd_q    <= m_rd_q;
            w_data_q  <= m_data;
        end
    end

    // Register the selected operands to execute.
    // Under stall or flush, issue a bubble and keep the previous operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            opr_q       <= '0;
            sel_q       <= '0;
            opr_valid_q <= 1'b0;
        end else if (flush || stall) begin
            opr_valid_q <= 1'b0;
        end else begin
            opr_q       <= opr_d;
            sel_q       <= sel_d;
            opr_valid_q <= id_valid;
        end
    end

    assign fwd_opr_a = opr_q[0];
    assign fwd_opr_b = opr_q[1];
    assign fwd_sel_a = sel_q[0];
    assign fwd_sel_b = sel_q[1];
    assign opr_valid = opr_valid_q;

endmodule

// File: tb/tb_operand_fwd_buffer.sv
// Bench for operand_fwd_buffer: directed scenarios plus a randomized run.
// Every cycle is compared against a producer-list reference model.
module tb_operand_fwd_buffer;
    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        ex_valid, ex_reg_wr, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] opr_res, mem_rdata;
    logic        flush;
    logic [31:0] fwd_opr_a, fwd_opr_b;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        opr_valid, stall;

    int n_chk  = 0;
    int n_fail = 0;

    operand_fwd_buffer dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ex_valid(ex_valid),
        .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .opr_res(opr_res),
        .mem_rdata(mem_rdata), .flush(flush), .fwd_opr_a(fwd_opr_a), .fwd_opr_b(fwd_opr_b),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .opr_valid(opr_valid), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the in-flight producers older than EX, plus the expected outputs.
    typedef struct packed {
        logic        v;
        logic        wr;
        logic        ld;
        logic [4:0]  rd;
        logic [31:0] d;
    } rec_t;

    rec_t        mm, mw;
    logic [31:0] e_opr [2];
    logic [1:0]  e_sel [2];
    logic        e_vld;

    wire [68:0] act_vec = {fwd_opr_a, fwd_opr_b, fwd_sel_a, fwd_sel_b, opr_valid};

    function automatic logic [68:0] exp_vec();
        return {e_opr[0], e_opr[1], e_sel[0], e_sel[1], e_vld};
    endfunction

    function automatic logic model_stall();
        return id_valid && ex_valid && ex_reg_wr && ex_is_load && ex_rd != 0 &&
               (ex_rd == id_rs1 || ex_rd == id_rs2) && !flush && !rst;
    endfunction

    // Scan the producers from oldest to youngest, so the youngest match wins.
    function automatic void pick(input logic [4:0] r, input logic [31:0] rf,
                                 output logic [1:0] s, output logic [31:0] d);
        rec_t c [3];
        c[0]   = '{ex_valid, ex_reg_wr, ex_is_load, ex_rd, opr_res};
        c[1]   = mm;
        c[1].d = mm.ld ? mem_rdata : mm.d;
        c[2]   = mw;
        s = 2'd0;
        d = rf;
        if (r != 0)
            for (int k = 2; k >= 0; k--)
                if (c[k].v && c[k].wr && c[k].rd == r) begin
                    s = 2'(k + 1);
                    d = c[k].d;
                end
    endfunction

    // One clock: evaluate the model on the pre-edge inputs, then commit after the edge.
    task automatic tick();
        logic        st;
        logic [1:0]  s0, s1;
        logic [31:0] d0, d1;
        rec_t        nm, nw;
        st = model_stall();
        pick(id_rs1, rf_rs1_data, s0, d0);
        pick(id_rs2, rf_rs2_data, s1, d1);
        nm   = '{ex_valid & ~flush, ex_reg_wr, ex_is_load, ex_rd, opr_res};
        nw   = mm;
        nw.d = mm.ld ? mem_rdata : mm.d;
        @(posedge clk);
        if (rst) begin
            mm = '0; mw = '0; e_opr[0] = 0; e_opr[1] = 0; e_sel[0] = 0; e_sel[1] = 0; e_vld = 0;
        end else begin
            mm = nm;
            mw = nw;
            if (flush || st) e_vld = 1'b0;
            else begin
                e_vld = id_valid; e_opr[0] = d0; e_opr[1] = d1; e_sel[0] = s0; e_sel[1] = s1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        ex_valid = 0; ex_reg_wr = 0; ex_is_load = 0; ex_rd = 0; opr_res = 0; mem_rdata = 0;
        flush = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; id_valid = 1; id_rs1 = 6; ex_valid = 1; ex_reg_wr = 1; ex_is_load = 1; ex_rd = 6;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        tick();
        n_chk++;
        if (act_vec !== 69'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", act_vec); end
        n_chk++;
        if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_model: got %h want %h", act_vec, exp_vec()); end
    endtask

    task automatic test_ex_fwd();
        idle();
        ex_valid = 1; ex_reg_wr = 1; ex_rd = 5; opr_res = 32'hAA;
        id_valid = 1; id_rs1 = 5; rf_rs1_data = 32'h11;
        tick();
        n_chk++;
        if ({fwd_opr_a, fwd_sel_a, opr_valid} !== {32'hAA, 2'b01, 1'b1}) begin
            n_fail++; $display("FAIL ex_fwd: got a=%h sel=%b v=%b want a=aa sel=01 v=1", fwd_opr_a, fwd_sel_a, opr_valid);
        end
        n_chk++;
        if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL ex_fwd_model: got %h want %h", act_vec, exp_vec()); end
    endtask

    task automatic test_load_use();
        idle();
        ex_valid = 1; ex_reg_wr = 1; ex_is_load = 1; ex_rd = 7; opr_res = 32'h1000;
        id_valid = 1; id_rs1 = 1; id_rs2 = 7; rf_rs1_data = 32'h21; rf_rs2_data = 32'h22;
        #1;
        n_chk++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
        tick();
        n_chk++;
        if (opr_valid !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got %b want 0", opr_valid); end
        n_chk++;
        if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL load_use_hold: got %h want %h", act_vec, exp_vec()); end
        ex_valid = 0; ex_is_load = 0; mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stall); end
        tick();
        n_chk++;
        if ({fwd_opr_b, fwd_sel_b, opr_valid} !== {32'hDEAD_BEEF, 2'b10, 1'b1}) begin
            n_fail++; $display("FAIL load_use_fwd: got b=%h sel=%b v=%b want deadbeef/10/1", fwd_opr_b, fwd_sel_b, opr_valid);
        end
        n_chk++;
        if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL load_use_model: got %h want %h", act_vec, exp_vec()); end
    endtask

    task automatic test_priority();
        for (int pass = 0; pass < 2; pass++) begin
            idle();
            ex_valid = 1; ex_reg_wr = 1; ex_rd = 3; opr_res = 32'h1;
            tick();
            opr_res = 32'h2;
            tick();
            opr_res = 32'h3; id_valid = 1; id_rs1 = 3; rf_rs1_data = 32'h99;
            if (pass == 1) ex_valid = 0;
            tick();
            n_chk++;
            if ({fwd_opr_a, fwd_sel_a} !== ((pass == 0) ? {32'h3, 2'b01} : {32'h2, 2'b10})) begin
                n_fail++; $display("FAIL priority_%0d: got a=%h sel=%b", pass, fwd_opr_a, fwd_sel_a);
            end
            n_chk++;
            if (act_vec !== exp_vec()) begin n_fail++; $display("FAIL priority_model: got %h want %h", act_vec, exp_vec()); end
        end
        // Only WB still holds rd=3 (value 0x2).
        ex_valid = 0;
        tick();
        n_chk++;
        if ({fwd_opr_a, fwd_sel_a} !== {32'h2, 2'b11}) begin
            n_fail++; $display("FAIL priority_wb: got a=%h sel=%b want 2/11", fwd_opr_a, fwd_sel_a);
        end
    endtask

    task automatic test_x0();
        idle();
        ex_valid = 1; ex_reg_wr = 1; ex_is_load = 1; ex_rd = 0; opr_res = 32'hFFFF_FFFF;
        id_valid = 1; id_rs1 = 0; id_rs2 = 0; rf_rs2_data = 32'h1234;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", stall); end
        tick();
        n_chk++;
        if (act_vec !== {32'h0, 32'h1234, 2'b00, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL x0_select: got %h", act_vec);
        end
    endtask

    task automatic test_flush();
        idle();
        tick();
        tick();
        ex_valid = 1; ex_reg_wr = 1; ex_is_load = 1; ex_rd = 9; opr_res = 32'h4444;
        id_valid = 1; id_rs1 = 9; rf_rs1_data = 32'h5555; flush = 1;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        n_chk++;
        if (opr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got %b want 0", opr_valid); end
        flush = 0; ex_valid = 0; ex_is_load = 0; mem_rdata = 32'hBAD0_BAD0;
        tick();
        n_chk++;
        if ({fwd_opr_a, fwd_sel_a, opr_valid} !== {32'h5555, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL flush_no_mem_fwd: got a=%h sel=%b v=%b want 5555/00/1", fwd_opr_a, fwd_sel_a, opr_valid);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        ex_valid = 1; ex_reg_wr = 1; ex_rd = 4; opr_res = 32'hABCD; id_valid = 1; id_rs1 = 4;
        tick();
        ex_is_load = 1; id_rs2 = 4; flush = 1; rst = 1;
        #1;
        n_chk++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
        tick();
        n_chk++;
        if (act_vec !== 69'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", act_vec); end
        rst = 0; flush = 0; ex_valid = 0; ex_is_load = 0; id_rs2 = 0; rf_rs1_data = 32'h77;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_chk++;
            if ({fwd_opr_a, fwd_sel_a} !== {32'h77, 2'b00}) begin
                n_fail++; $display("FAIL rst_mid_rf_%0d: got a=%h sel=%b want 77/00", c, fwd_opr_a, fwd_sel_a);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 31) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            id_valid    = $urandom_range(0, 3) != 0;
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            rf_rs1_data = $urandom;
            rf_rs2_data = $urandom;
            ex_valid    = $urandom_range(0, 3) != 0;
            ex_reg_wr   = $urandom_range(0, 3) != 0;
            ex_is_load  = $urandom_range(0, 3) == 0;
            ex_rd       = 5'($urandom_range(0, 7));
            opr_res     = $urandom;
            mem_rdata   = $urandom;
            #1;
            n_chk++;
            if (stall !== model_stall()) begin
                n_fail++; $display("FAIL rand_stall c=%0d: got %b want %b", c, stall, model_stall());
            end
            tick();
            n_chk++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rand_out c=%0d: got %h want %h", c, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        mm = '0; mw = '0; e_opr[0] = 0; e_opr[1] = 0; e_sel[0] = 0; e_sel[1] = 0; e_vld = 0;
        idle();
        rst = 1;
        #2;
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_priority();
        test_x0();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
